// File: rtl/pe_seq_ctrl_if.sv
// Handshake and PE packet bundle between a job source and pe_seq_ctrl.
// The sequencer takes the slave modport; the job source takes the master modport.
interface pe_seq_ctrl_if;
  logic        start;
  logic [3:0]  num_win;
  logic        wt_valid;
  logic [7:0]  wt_data;
  logic        wt_ready;
  logic        act_valid;
  logic [31:0] act_data;
  logic        act_ready;
  logic [2:0]  pe_state;
  logic [31:0] pe_a;
  logic [7:0]  pe_wrb_data;
  logic [3:0]  pe_wrb_addr;
  logic [3:0]  pe_wrb;
  logic [3:0]  pe_rdb_addr;
  logic        busy;
  logic        done;

  modport master (
    output start, num_win, wt_valid, wt_data, act_valid, act_data,
    input  wt_ready, act_ready, pe_state, pe_a, pe_wrb_data, pe_wrb_addr, pe_wrb,
           pe_rdb_addr, busy, done
  );

  modport slave (
    input  start, num_win, wt_valid, wt_data, act_valid, act_data,
    output wt_ready, act_ready, pe_state, pe_a, pe_wrb_data, pe_wrb_addr, pe_wrb,
           pe_rdb_addr, busy, done
  );
endinterface

// File: rtl/pe_seq_ctrl.sv
// PE job sequencer: loads 9 weights, then streams 9-beat activation windows as PE packets.
// Define PE_SEQ_POOL_EN to insert a POOL_FIN packet after every 4 windows and after the last.
module pe_seq_ctrl (
  input logic          clk,
  input logic          reset,
  pe_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StRun,
`ifdef PE_SEQ_POOL_EN
    StPool,
`endif
    StDone
  } state_e;

  localparam logic [2:0] PeInvalid = 3'd0;
  localparam logic [2:0] PeValid   = 3'd1;
  localparam logic [2:0] PeCnnFin  = 3'd2;
`ifdef PE_SEQ_POOL_EN
  localparam logic [2:0] PePoolFin = 3'd3;
`endif

  state_e      state_q;
  logic [3:0]  beat_q;
  logic [4:0]  win_q;
  logic [4:0]  num_win_q;
`ifdef PE_SEQ_POOL_EN
  logic [2:0]  since_pool_q;
`endif
  logic [2:0]  pe_state_q;
  logic [31:0] pe_a_q;
  logic [7:0]  pe_wrb_data_q;
  logic [3:0]  pe_wrb_addr_q;
  logic [3:0]  pe_wrb_q;
  logic [3:0]  pe_rdb_addr_q;
  logic        done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      beat_q        <= '0;
      win_q         <= '0;
      num_win_q     <= '0;
`ifdef PE_SEQ_POOL_EN
      since_pool_q  <= '0;
`endif
      pe_state_q    <= PeInvalid;
      pe_a_q        <= '0;
      pe_wrb_data_q <= '0;
      pe_wrb_addr_q <= '0;
      pe_wrb_q      <= '0;
      pe_rdb_addr_q <= '0;
      done_q        <= 1'b0;
    end else begin
      // Packets are single-cycle: everything but rdb_addr falls back to zero unless driven.
      pe_state_q    <= PeInvalid;
      pe_a_q        <= '0;
      pe_wrb_data_q <= '0;
      pe_wrb_addr_q <= '0;
      pe_wrb_q      <= '0;
      done_q        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          pe_rdb_addr_q <= '0;
          if (bus.start) begin
            num_win_q    <= (bus.num_win == 4'd0) ? 5'd16 : {1'b0, bus.num_win};
            beat_q       <= '0;
            win_q        <= '0;
`ifdef PE_SEQ_POOL_EN
            since_pool_q <= '0;
`endif
            state_q      <= StLoadW;
          end
        end
        StLoadW: begin
          pe_rdb_addr_q <= '0;
          if (bus.wt_valid) begin
            pe_wrb_q      <= 4'b1111;
            pe_wrb_addr_q <= beat_q;
            pe_wrb_data_q <= bus.wt_data;
            if (beat_q == 4'd8) begin
              beat_q  <= '0;
              state_q <= StRun;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end
        StRun: begin
          // On a stall rdb_addr keeps the last beat index issued.
          if (bus.act_valid) begin
            pe_a_q        <= bus.act_data;
            pe_rdb_addr_q <= beat_q;
            pe_state_q    <= (beat_q == 4'd8) ? PeCnnFin : PeValid;
            if (beat_q == 4'd8) begin
              beat_q <= '0;
              win_q  <= win_q + 5'd1;
`ifdef PE_SEQ_POOL_EN
              since_pool_q <= since_pool_q + 3'd1;
              if (since_pool_q == 3'd3 || win_q + 5'd1 == num_win_q) begin
                state_q <= StPool;
              end
`else
              if (win_q + 5'd1 == num_win_q) begin
                state_q <= StDone;
              end
`endif
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end
`ifdef PE_SEQ_POOL_EN
        StPool: begin
          pe_state_q    <= PePoolFin;
          pe_rdb_addr_q <= '0;
          since_pool_q  <= '0;
          state_q       <= (win_q == num_win_q) ? StDone : StRun;
        end
`endif
        StDone: begin
          pe_rdb_addr_q <= '0;
          done_q        <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.wt_ready    = (state_q == StLoadW);
  assign bus.act_ready   = (state_q == StRun);
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.pe_state    = pe_state_q;
  assign bus.pe_a        = pe_a_q;
  assign bus.pe_wrb_data = pe_wrb_data_q;
  assign bus.pe_wrb_addr = pe_wrb_addr_q;
  assign bus.pe_wrb      = pe_wrb_q;
  assign bus.pe_rdb_addr = pe_rdb_addr_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl: each job pushes its expected packet stream, a negedge
// monitor pops and compares every active packet. Honours PE_SEQ_POOL_EN like the design.
module tb_pe_seq_ctrl;

  logic clk;
  logic reset;
  pe_seq_ctrl_if bus ();

  pe_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int done_cnt;
  int pool_cnt;
  int exp_done;
  logic [54:0] sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [54:0] mk_pkt(input logic [2:0] st, input logic [31:0] a,
                                         input logic [7:0] wd, input logic [3:0] wa,
                                         input logic [3:0] wrb, input logic [3:0] ra);
    return {st, a, wd, wa, wrb, ra};
  endfunction

  function automatic logic [31:0] act_word(input int w, input int b);
    return 32'h3020_1000 + 32'(b) * 32'h0101_0101 + 32'(w) * 32'h0404_0404;
  endfunction

  // Monitor: active packets are scoreboarded, idle cycles must carry zero payload.
  always @(negedge clk) begin
    if (reset) begin
      logic [54:0] pkt;
      logic [54:0] exp_pkt;
      pkt = {bus.pe_state, bus.pe_a, bus.pe_wrb_data, bus.pe_wrb_addr, bus.pe_wrb,
             bus.pe_rdb_addr};
      check("rdy_excl", 64'(bus.wt_ready & bus.act_ready), 64'd0);
      if (bus.pe_state != 3'd0 || bus.pe_wrb != 4'd0) begin
        if (bus.pe_state == 3'd3) pool_cnt++;
        if (sb.size() == 0) begin
          check("extra_pkt", 64'(pkt), 64'd0);
        end else begin
          exp_pkt = sb.pop_front();
          check("pkt", 64'(pkt), 64'(exp_pkt));
        end
      end else begin
        check("idle_payload", {20'd0, bus.pe_a, bus.pe_wrb_data, bus.pe_wrb_addr},
              64'd0);
      end
      if (bus.done) begin
        check("done_sb_empty", 64'(sb.size()), 64'd0);
        done_cnt++;
      end
    end
  end

  task automatic drive_wt(input logic [7:0] d);
    int n = 0;
    bus.wt_valid = 1'b1;
    bus.wt_data  = d;
    while (!bus.wt_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("wt_ready_to", 64'(bus.wt_ready), 64'd1);
    @(negedge clk);
    bus.wt_valid = 1'b0;
  endtask

  task automatic drive_act(input logic [31:0] d);
    int n = 0;
    bus.act_valid = 1'b1;
    bus.act_data  = d;
    while (!bus.act_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("act_ready_to", 64'(bus.act_ready), 64'd1);
    @(negedge clk);
    bus.act_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 64'(bus.pe_state), 64'd0);
    check({tag, "_payload"}, {9'd0, bus.pe_a, bus.pe_wrb_data, bus.pe_wrb_addr, bus.pe_wrb,
          bus.pe_rdb_addr}, 64'd0);
    check({tag, "_ctrl"}, {60'd0, bus.wt_ready, bus.act_ready, bus.busy, bus.done}, 64'd0);
  endtask

  // Runs one job. stall_win: window whose beat 5 is preceded by a 3-cycle stall (-1: none).
  // abort_beat: reset is asserted right after this beat of window 0 (-1: none).
  task automatic run_job(input int nw, input int stall_win, input int abort_beat,
                         input logic [7:0] wbase);
    int since = 0;
    int pools = 0;
    int pool_base;
    bit aborted = 0;
    int n = 0;
    pool_base = pool_cnt;
    for (int i = 0; i < 9; i++) sb.push_back(mk_pkt(3'd0, 32'd0, wbase + 8'(i), 4'(i), 4'hF, 4'd0));
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 9; b++)
        sb.push_back(mk_pkt((b == 8) ? 3'd2 : 3'd1, act_word(w, b), 8'd0, 4'd0, 4'd0, 4'(b)));
      since++;
`ifdef PE_SEQ_POOL_EN
      if (since == 4 || w == nw - 1) begin
        sb.push_back(mk_pkt(3'd3, 32'd0, 8'd0, 4'd0, 4'd0, 4'd0));
        pools++;
        since = 0;
      end
`endif
    end

    bus.start   = 1'b1;
    bus.num_win = 4'(nw);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 9; i++) drive_wt(wbase + 8'(i));

    for (int w = 0; w < nw && !aborted; w++) begin
      for (int b = 0; b < 9; b++) begin
        if (w == stall_win && b == 5) begin
          // A start during the stall must be ignored while busy.
          bus.start   = 1'b1;
          bus.num_win = 4'd7;
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check("stall_state", 64'(bus.pe_state), 64'd0);
            check("stall_rdb", 64'(bus.pe_rdb_addr), 64'd4);
          end
        end
        drive_act(act_word(w, b));
        if (w == 0 && b == abort_beat) begin
          #2 reset = 1'b0;
          #1 check_reset_outputs("rst_mid");
          sb.delete();
          @(negedge clk);
          reset = 1'b1;
          aborted = 1;
          break;
        end
      end
    end

    if (!aborted) begin
      exp_done++;
      while (done_cnt < exp_done && n < 64) begin
        @(negedge clk);
        n++;
      end
      check("done_seen", 64'(done_cnt), 64'(exp_done));
      check("pool_count", 64'(pool_cnt - pool_base), 64'(pools));
      @(negedge clk);
      check("idle_after_done", 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; pool_cnt = 0; exp_done = 0;
    bus.start = 1'b0; bus.num_win = 4'd0;
    bus.wt_valid = 1'b0; bus.wt_data = 8'd0;
    bus.act_valid = 1'b0; bus.act_data = 32'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 check_reset_outputs("rst_init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_job(1, -1, -1, 8'd1);     // weights 1..9, single window
    run_job(1, 0, -1, 8'd20);     // stall after beat 4
    run_job(5, -1, -1, 8'd40);    // pool grouping 4 + 1
    run_job(2, -1, 6, 8'd60);     // reset after beat 6, job abandoned
    repeat (3) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt), 64'(exp_done));
    run_job(1, -1, -1, 8'd80);    // fresh job reloads weights from addr 0
    run_job(4, -1, -1, 8'd100);   // 36 beats
    run_job(16, -1, -1, 8'd120);  // num_win=0 encodes 16

    repeat (4) @(negedge clk);
    check("done_total", 64'(done_cnt), 64'(exp_done));
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
